pipeline_memp_stage_n: RTL
==========================

Name: pipeline_memp_stage_n

Overview:
Parametrised memory-prepare pipeline stage sitting between the EXA and MEMD stages. Decodes the access address against NUM_TGT address regions, which replaces the fixed bus/DRAM split. Issues the access to the selected target over a per-target valid/ready handshake and holds it until the target accepts. Forwards pipeline fields to MEMD with a valid flag; reports decode faults and, optionally, misalignment.

Parameters:
XLEN, 64, data/address width
NUM_TGT, 2, number of target channels (>=1)
TGT_BASE, {64'h8000_0000, 64'h0}, packed NUM_TGT*XLEN region bases; index 0 in the LSBs
TGT_MASK, {2{64'hFFFF_FFFF_8000_0000}}, packed NUM_TGT*XLEN region masks

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
stall_in  in  1  downstream (MEMD) stall
flush  in  1  kill the current entry
in_valid  in  1  EXA entry valid
in_ready  out  1  stage can capture
pc_in  in  XLEN  PC
rf_wr_en_in  in  1  register write enable
rf_wr_sel_in  in  2  write-back select
alu_result_in  in  XLEN  address / ALU result
dm_rd_ctrl_in  in  3  read control (0 = none)
dm_wr_ctrl_in  in  3  write control (0 = none)
wdata_in  in  XLEN  store data
rd_in  in  5  destination register
tgt_req_valid  out  NUM_TGT  one-hot request valid
tgt_req_ready  in  NUM_TGT  per-target accept
tgt_addr  out  XLEN  shared request address
tgt_wdata  out  XLEN  shared store data
tgt_rd_ctrl  out  3  shared read control
tgt_wr_ctrl  out  3  shared write control
out_valid  out  1  MEMD entry valid
pc_out, alu_result_out  out  XLEN  forwarded fields
rf_wr_sel_out  out  2  forwarded field
rf_wr_en_out  out  1  forwarded field
rd_out  out  5  forwarded field
tgt_sel_out  out  NUM_TGT  one-hot target of the entry (0 = no memory access)
fault_out  out  1  memory op matched no region
misalign_out  out  1  misaligned access (feature)

Behaviour:
- Reset (reset=0): all outputs 0, state IDLE.
- Decode (combinational): hit[i] = ((alu_result_in & MASK[i]) == BASE[i]). Lowest index wins. Evaluated only when rd_ctrl or wr_ctrl is nonzero.
- FSM states IDLE and WAIT.
- in_ready = (state==IDLE) & ~stall_in. WAIT never accepts.
- IDLE & stall_in: all registers hold.
- IDLE & ~stall_in & ~in_valid: out_valid<=0; the other fields hold.
- IDLE capture (in_valid & in_ready):
  - All forwarded fields are loaded and tgt_sel_out<=decoded one-hot.
  - Memory op with a hit: tgt_req_valid[idx]<=1; tgt_addr, tgt_wdata and the ctrl outputs are loaded; out_valid<=0; next state WAIT.
  - Non-memory op: out_valid<=1; no request.
  - Memory op with no hit: fault_out<=1, rf_wr_en_out<=0, out_valid<=1; no request.
- WAIT: tgt_* are held stable regardless of stall_in.
  - Handshake = tgt_req_valid[idx] & tgt_req_ready[idx] at a clock edge.
  - On handshake: tgt_req_valid<=0, ctrl outputs<=0, out_valid<=1, next state IDLE. out_valid then holds while stall_in is high.
- Latency: non-memory op 1 cycle. Memory op is 1 cycle plus the target wait plus 1 cycle. Minimum 2 cycles, with one input bubble per access.
- flush:
  - In IDLE: out_valid<=0 and no capture that cycle.
  - In WAIT: the request is never withdrawn. The entry is marked killed; on handshake out_valid stays 0 and rf_wr_en_out<=0.
- fault_out and misalign_out are cleared on every capture of a clean entry.
- tgt_req_ready on a non-selected target is ignored.

Optional Feature:
MEMP_MISALIGN_TRAP_EN
- Enabled: size is decoded from the ctrl fields. rd 1,2→1B; 3,4→2B; 5,6→4B; 7→8B. wr 1→1B, 2→2B, 3→4B, 4→8B.
  - On capture, if alu_result_in mod size != 0: misalign_out<=1, rf_wr_en_out<=0, out_valid<=1; no request issued.
  - A misaligned access takes priority over a decode fault.
- Disabled: misalign_out is constant 0 and no alignment check is made.

Test Plan:
- ADD entry, pc=0x100, alu=0x5 -> out_valid=1 next cycle, tgt_sel_out=0, tgt_req_valid=0.
- LD (rd=7) to alu=0x8000_0010, tgt_req_ready[1] held 0 for 3 cycles -> tgt_req_valid=2'b10 held stable with addr 0x8000_0010 and in_ready=0; out_valid=1 the cycle after ready rises.
- SW (wr=3) to 0x1000, wdata=0xDEAD_BEEF, ready=1 immediately -> tgt_req_valid=2'b01 for one cycle, tgt_wdata=0xDEAD_BEEF, out_valid=1 two cycles after capture.
- Custom regions with no hit (e.g. NUM_TGT=1, BASE=0x8000_0000) and LD to 0x10 -> fault_out=1, rf_wr_en_out=0, no tgt_req_valid.
- flush asserted while in WAIT -> tgt_req_valid stays 1 until handshake, then out_valid stays 0 and rf_wr_en_out=0. Separately, reset asserted mid-WAIT -> all outputs 0 immediately.
- With MEMP_MISALIGN_TRAP_EN: LH to 0x8000_0001 -> misalign_out=1, no request. Without the macro the same op issues the request normally.

Source files
------------

// File: rtl/pipeline_memp_stage_n.sv
// pipeline_memp_stage_n: memory-prepare stage decoding NUM_TGT regions and issuing valid/ready target requests.
// Optional alignment trap enabled by defining MEMP_MISALIGN_TRAP_EN.
module pipeline_memp_stage_n #(
    parameter int XLEN = 64,
    parameter int NUM_TGT = 2,
    parameter logic [NUM_TGT*XLEN-1:0] TGT_BASE = {64'h8000_0000, 64'h0},
    parameter logic [NUM_TGT*XLEN-1:0] TGT_MASK = {2{64'hFFFF_FFFF_8000_0000}}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_in,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    pc_in,
    input  logic               rf_wr_en_in,
    input  logic [1:0]         rf_wr_sel_in,
    input  logic [XLEN-1:0]    alu_result_in,
    input  logic [2:0]         dm_rd_ctrl_in,
    input  logic [2:0]         dm_wr_ctrl_in,
    input  logic [XLEN-1:0]    wdata_in,
    input  logic [4:0]         rd_in,
    output logic [NUM_TGT-1:0] tgt_req_valid,
    input  logic [NUM_TGT-1:0] tgt_req_ready,
    output logic [XLEN-1:0]    tgt_addr,
    output logic [XLEN-1:0]    tgt_wdata,
    output logic [2:0]         tgt_rd_ctrl,
    output logic [2:0]         tgt_wr_ctrl,
    output logic               out_valid,
    output logic [XLEN-1:0]    pc_out,
    output logic [XLEN-1:0]    alu_result_out,
    output logic [1:0]         rf_wr_sel_out,
    output logic               rf_wr_en_out,
    output logic [4:0]         rd_out,
    output logic [NUM_TGT-1:0] tgt_sel_out,
    output logic               fault_out,
    output logic               misalign_out
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state;
    logic killed, mem, nohit, mis, kill_now;
    logic [NUM_TGT-1:0] sel;

    assign in_ready = reset && state == IDLE && !stall_in;
    assign kill_now = killed || flush;

    // descending scan so the lowest matching index is the final assignment
    always_comb begin
        mem = |{dm_rd_ctrl_in, dm_wr_ctrl_in};
        sel = '0;
        for (int i = NUM_TGT - 1; i >= 0; i--)
            if (mem && (alu_result_in & TGT_MASK[i*XLEN +: XLEN]) == TGT_BASE[i*XLEN +: XLEN])
                sel = NUM_TGT'(1) << i;
        nohit = mem && sel == '0;
    end

`ifdef MEMP_MISALIGN_TRAP_EN
    logic [2:0] lsb;
    always_comb begin
        lsb = dm_rd_ctrl_in != 3'd0
            ? (dm_rd_ctrl_in == 3'd7 ? 3'd7 : dm_rd_ctrl_in >= 3'd5 ? 3'd3 : dm_rd_ctrl_in >= 3'd3 ? 3'd1 : 3'd0)
            : (dm_wr_ctrl_in >= 3'd4 ? 3'd7 : dm_wr_ctrl_in == 3'd3 ? 3'd3 : dm_wr_ctrl_in == 3'd2 ? 3'd1 : 3'd0);
        mis = |(alu_result_in[2:0] & lsb);
    end
`else
    assign mis = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            killed         <= 1'b0;
            tgt_req_valid  <= '0;
            tgt_addr       <= '0;
            tgt_wdata      <= '0;
            tgt_rd_ctrl    <= '0;
            tgt_wr_ctrl    <= '0;
            out_valid      <= 1'b0;
            pc_out         <= '0;
            alu_result_out <= '0;
            rf_wr_sel_out  <= '0;
            rf_wr_en_out   <= 1'b0;
            rd_out         <= '0;
            tgt_sel_out    <= '0;
            fault_out      <= 1'b0;
            misalign_out   <= 1'b0;
        end else if (state == IDLE) begin
            if (!stall_in) begin
                out_valid <= 1'b0;
                if (in_valid && !flush) begin
                    pc_out         <= pc_in;
                    alu_result_out <= alu_result_in;
                    rf_wr_sel_out  <= rf_wr_sel_in;
                    rd_out         <= rd_in;
                    tgt_sel_out    <= sel;
                    rf_wr_en_out   <= rf_wr_en_in && !mis && !nohit;
                    misalign_out   <= mis;
                    fault_out      <= !mis && nohit;
                    killed         <= 1'b0;
                    if (mem && !mis && !nohit) begin
                        tgt_req_valid <= sel;
                        tgt_addr      <= alu_result_in;
                        tgt_wdata     <= wdata_in;
                        tgt_rd_ctrl   <= dm_rd_ctrl_in;
                        tgt_wr_ctrl   <= dm_wr_ctrl_in;
                        state         <= WAIT;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
            end
        end else begin
            if (flush)
                killed <= 1'b1;
            // request is never withdrawn; a flushed entry completes silently
            if (|(tgt_req_valid & tgt_req_ready)) begin
                tgt_req_valid <= '0;
                tgt_rd_ctrl   <= '0;
                tgt_wr_ctrl   <= '0;
                out_valid     <= !kill_now;
                if (kill_now)
                    rf_wr_en_out <= 1'b0;
                state <= IDLE;
            end
        end
    end
endmodule
